// File: rtl/knight_pkg.sv
// Shared definitions for the KnightsTour command path.
//   - opcode and heading constants used to build 16-bit board-move commands
//   - response bytes returned to the UART wrapper
//   - state enum of the tour command sequencer
//   - mk_cmd(): packs {opcode, heading, square count} into one command word
package knight_pkg;

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_E = 8'h3F;
  localparam logic [7:0] HEAD_W = 8'h7F;
  localparam logic [7:0] HEAD_S = 8'hFF;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } tour_cmd_state_t;

  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] head,
                                         input logic [3:0] cnt);
    return {op, head, cnt};
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Combinational decode of one knight move into two board-move commands.
// Ports:
//   move     in  8  one-hot knight move from the solver (lowest set bit wins)
//   vert_cmd out 16 vertical leg, plain move opcode
//   horz_cmd out 16 horizontal leg, fanfare opcode
// An all-zero move yields zero-square commands heading north.
module tour_move_decode
  import knight_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  always_comb begin
    vert_cmd = mk_cmd(OP_MOVE,    HEAD_N, 4'd0);
    horz_cmd = mk_cmd(OP_FANFARE, HEAD_N, 4'd0);
    casez (move)
      8'b???????1: begin
        vert_cmd = mk_cmd(OP_MOVE,    HEAD_N, 4'd2);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_E, 4'd1);
      end
      8'b??????10: begin
        vert_cmd = mk_cmd(OP_MOVE,    HEAD_N, 4'd2);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_W, 4'd1);
      end
      8'b?????100: begin
        vert_cmd = mk_cmd(OP_MOVE,    HEAD_N, 4'd1);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_W, 4'd2);
      end
      8'b????1000: begin
        vert_cmd = mk_cmd(OP_MOVE,    HEAD_S, 4'd1);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_W, 4'd2);
      end
      8'b???10000: begin
        vert_cmd = mk_cmd(OP_MOVE,    HEAD_S, 4'd2);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_W, 4'd1);
      end
      8'b??100000: begin
        vert_cmd = mk_cmd(OP_MOVE,    HEAD_S, 4'd2);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_E, 4'd1);
      end
      8'b?1000000: begin
        vert_cmd = mk_cmd(OP_MOVE,    HEAD_S, 4'd1);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_E, 4'd2);
      end
      8'b10000000: begin
        vert_cmd = mk_cmd(OP_MOVE,    HEAD_N, 4'd1);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_E, 4'd2);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Tour command sequencer: splits each solved knight move into a vertical
// then a horizontal board-move command and hands them to the command
// processor over the cmd/cmd_rdy handshake. While idle, UART commands pass
// straight through.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_tour            pulse: solved tour is ready
//   move / mv_indx        solver memory read data / address
//   cmd_UART, cmd_rdy_UART UART command path (used when idle)
//   clr_cmd_rdy           command processor accepted cmd
//   send_resp             command processor finished the command
//   cmd, cmd_rdy          command to the command processor
//   resp                  response byte to the UART wrapper
module tour_cmd
  import knight_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  tour_cmd_state_t state, state_nxt;
  logic [15:0]     vert_cmd, horz_cmd;
  logic            mv_clr, mv_inc;
  logic            last_mv;

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  assign last_mv = (mv_indx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= 5'd0;
    end else begin
      state <= state_nxt;
      if (mv_clr)
        mv_indx <= 5'd0;
      else if (mv_inc)
        mv_indx <= mv_indx + 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    mv_clr    = 1'b0;
    mv_inc    = 1'b0;
    cmd       = cmd_UART;
    cmd_rdy   = 1'b0;
    resp      = RESP_POS;
    unique case (state)
      IDLE: begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_ACK;
        if (start_tour) begin
          mv_clr    = 1'b1;
          state_nxt = VERT;
        end
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        // clr_cmd_rdy has priority; a simultaneous send_resp is dropped
        if (clr_cmd_rdy) state_nxt = WAIT_V;
      end
      WAIT_V: begin
        cmd = vert_cmd;
        if (send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = WAIT_H;
      end
      WAIT_H: begin
        cmd = horz_cmd;
        // the final leg reports tour completion to the UART side
        if (last_mv) resp = RESP_ACK;
        if (send_resp) begin
          if (last_mv) begin
            state_nxt = IDLE;
          end else begin
            mv_inc    = 1'b1;
            state_nxt = VERT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  int n_chk = 0;
  int n_err = 0;

  // hand-computed vertical / horizontal commands for one-hot bit 0..7
  logic [15:0] vt [8];
  logic [15:0] ht [8];

  tour_cmd #(.NUM_MOVES(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .resp         (resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one full knight move: VERT -> WAIT_V -> HORZ -> WAIT_H -> (next)
  task automatic do_move(input logic [4:0] idx, input logic [15:0] ev,
                         input logic [15:0] eh, input bit last);
    #1;
    chk("vert_idx",  16'(mv_indx), 16'(idx));
    chk("vert_cmd",  cmd, ev);
    chk("vert_rdy",  16'(cmd_rdy), 16'd1);
    chk("vert_resp", 16'(resp), 16'h5A);
    clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0; #1;
    chk("waitv_rdy", 16'(cmd_rdy), 16'd0);
    chk("waitv_cmd", cmd, ev);
    send_resp = 1'b1; tick; send_resp = 1'b0; #1;
    chk("horz_cmd",  cmd, eh);
    chk("horz_rdy",  16'(cmd_rdy), 16'd1);
    clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0; #1;
    chk("waith_rdy", 16'(cmd_rdy), 16'd0);
    chk("waith_resp", 16'(resp), last ? 16'hA5 : 16'h5A);
    send_resp = 1'b1; tick; send_resp = 1'b0;
  endtask

  initial begin
    vt[0] = 16'h2002; ht[0] = 16'h33F1;
    vt[1] = 16'h2002; ht[1] = 16'h37F1;
    vt[2] = 16'h2001; ht[2] = 16'h37F2;
    vt[3] = 16'h2FF1; ht[3] = 16'h37F2;
    vt[4] = 16'h2FF2; ht[4] = 16'h37F1;
    vt[5] = 16'h2FF2; ht[5] = 16'h33F1;
    vt[6] = 16'h2FF1; ht[6] = 16'h33F2;
    vt[7] = 16'h2001; ht[7] = 16'h33F2;

    rst_n = 1'b0; start_tour = 1'b0; move = 8'h01;
    cmd_UART = 16'h4022; cmd_rdy_UART = 1'b1;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    #23;
    chk("rst_cmd",  cmd, 16'h4022);
    chk("rst_rdy",  16'(cmd_rdy), 16'd1);
    chk("rst_resp", 16'(resp), 16'hA5);
    chk("rst_idx",  16'(mv_indx), 16'd0);
    rst_n = 1'b1;
    tick;
    cmd_rdy_UART = 1'b0; #1;
    chk("idle_rdy_follow", 16'(cmd_rdy), 16'd0);

    // full 24-move tour, move pattern cycles through all eight one-hot bits
    start_tour = 1'b1; tick; start_tour = 1'b0;
    for (int i = 0; i < 24; i++) begin
      move = 8'h01 << (i % 8);
      do_move(5'(i), vt[i % 8], ht[i % 8], i == 23);
    end
    #1;
    chk("end_idle_cmd",  cmd, 16'h4022);
    chk("end_idle_rdy",  16'(cmd_rdy), 16'd0);
    chk("end_idle_resp", 16'(resp), 16'hA5);
    chk("end_idx",       16'(mv_indx), 16'd23);

    // second tour: all-zero move, then non-one-hot move, with interference
    move = 8'h00;
    start_tour = 1'b1; tick; start_tour = 1'b0;
    do_move(5'd0, 16'h2000, 16'h3000, 1'b0);
    move = 8'h0C;   // bits 2 and 3 set: bit 2 wins
    #1;
    chk("multi_vert", cmd, 16'h2001);
    clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0;
    clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0; #1;   // ignored in WAIT_V
    chk("waitv_clr_ign", 16'(cmd_rdy), 16'd0);
    chk("waitv_clr_cmd", cmd, 16'h2001);
    send_resp = 1'b1; tick; send_resp = 1'b0; #1;
    chk("multi_horz", cmd, 16'h37F2);
    // interference in HORZ
    cmd_UART = 16'h5123; cmd_rdy_UART = 1'b1;
    start_tour = 1'b1; send_resp = 1'b1; tick;
    start_tour = 1'b0; send_resp = 1'b0; #1;
    chk("intf_cmd",  cmd, 16'h37F2);
    chk("intf_rdy",  16'(cmd_rdy), 16'd1);
    chk("intf_idx",  16'(mv_indx), 16'd1);
    chk("intf_resp", 16'(resp), 16'h5A);
    clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0;
    send_resp = 1'b1; tick; send_resp = 1'b0; #1;
    chk("idx_two", 16'(mv_indx), 16'd2);
    // clr and send together in VERT: only clr acted on -> WAIT_V
    clr_cmd_rdy = 1'b1; send_resp = 1'b1; tick;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; #1;
    chk("both_rdy", 16'(cmd_rdy), 16'd0);
    chk("both_cmd", cmd, 16'h2001);
    // asynchronous reset while in WAIT_V
    #2 rst_n = 1'b0; #1;
    chk("arst_cmd",  cmd, 16'h5123);
    chk("arst_rdy",  16'(cmd_rdy), 16'd1);
    chk("arst_idx",  16'(mv_indx), 16'd0);
    chk("arst_resp", 16'(resp), 16'hA5);
    cmd_rdy_UART = 1'b0; #1;
    chk("arst_rdy_follow", 16'(cmd_rdy), 16'd0);
    rst_n = 1'b1;
    tick;
    chk("post_rst_cmd", cmd, 16'h5123);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tour_cmd.md
# tour_cmd

Command-sequencing stage between the tour solver and the command processor in the KnightsTour datapath. Once `start_tour` fires, it reads the solved tour one move at a time and breaks each L-shaped knight move into two board-move commands: a vertical move, then a horizontal move with fanfare. It issues these to the command processor through the same `cmd`/`cmd_rdy` handshake the UART path uses. When idle, it passes UART commands through unchanged and returns the standard acknowledge byte.

## Interface
- `NUM_MOVES`, default 24: number of knight moves in a 5x5 tour (indices 0..NUM_MOVES-1).
- `clk` in 1: system clock. The block uses this single clock only.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_tour` in 1: one-cycle pulse from the tour solver; the tour has been computed.
- `move` in 8: one-hot move read from the solver at index `mv_indx`.
- `mv_indx` out 5: index of the move currently being executed.
- `cmd_UART` in 16: command word from the UART wrapper.
- `cmd_rdy_UART` in 1: the UART command is valid.
- `clr_cmd_rdy` in 1: the command processor has accepted `cmd`.
- `send_resp` in 1: the command processor has finished executing the command.
- `cmd` out 16: command word to the command processor.
- `cmd_rdy` out 1: `cmd` is valid.
- `resp` out 8: response byte to the UART wrapper.

## Operation
- Command format:
  - [15:12] opcode: 0x2 = move, 0x3 = move with fanfare.
  - [11:4] heading: 0x00 = N, 0x3F = E, 0x7F = W, 0xFF = S.
  - [3:0] square count.
- `move` decode (bit: dx,dy → vertical cmd / horizontal cmd):
  - bit0: +1,+2 → N2 / E1
  - bit1: -1,+2 → N2 / W1
  - bit2: -2,+1 → N1 / W2
  - bit3: -2,-1 → S1 / W2
  - bit4: -1,-2 → S2 / W1
  - bit5: +1,-2 → S2 / E1
  - bit6: +2,-1 → S1 / E2
  - bit7: +2,+1 → N1 / E2
- Vertical commands use opcode 0x2; horizontal commands use 0x3. Example: bit0 → 16'h2002 then 16'h33F1.
- If `move` is not one-hot, the lowest set bit wins. All-zero produces 16'h2000 then 16'h3000.
- FSM states: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`. On `start_tour`, clear `mv_indx` to 0 and go to VERT.
  - VERT: `cmd`=vertical command, `cmd_rdy`=1. On `clr_cmd_rdy`, go to WAIT_V.
  - WAIT_V: `cmd_rdy`=0, `cmd` holds the vertical command. On `send_resp`, go to HORZ.
  - HORZ: `cmd`=horizontal command, `cmd_rdy`=1. On `clr_cmd_rdy`, go to WAIT_H.
  - WAIT_H: `cmd_rdy`=0. On `send_resp`:
    - if `mv_indx`==NUM_MOVES-1, go to IDLE;
    - otherwise increment `mv_indx` and go to VERT.
- `resp` is 8'hA5 in IDLE, and in WAIT_H when `mv_indx`==NUM_MOVES-1. In every other case it is 8'h5A (tour in progress).

## Timing
- Reset values:
  - state = IDLE, `mv_indx` = 0.
  - So `cmd` = `cmd_UART`, `cmd_rdy` = `cmd_rdy_UART`, `resp` = 8'hA5.
- `cmd`, `cmd_rdy` and `resp` are combinational from the state, `mv_indx` and `move`. `move` must be stable while `mv_indx` is stable (solver memory read).
- `start_tour` at edge N puts the block in VERT at N+1, with `cmd_rdy`=1 in that same cycle.
- `clr_cmd_rdy` sampled in VERT/HORZ drops `cmd_rdy` on the next cycle.
- Wrap-around: `mv_indx` increments only in WAIT_H and never exceeds NUM_MOVES-1.
- Ignored events:
  - `start_tour` outside IDLE.
  - `cmd_rdy_UART` outside IDLE; the wrapper keeps it pending until the tour ends.
  - `send_resp` in VERT/HORZ.
  - `clr_cmd_rdy` in WAIT_V/WAIT_H.
- `clr_cmd_rdy` and `send_resp` arriving together in VERT: only `clr_cmd_rdy` is acted on.
- Reset asserted mid-tour: the block returns to IDLE immediately (asynchronously); no partial command is reissued.

## Structure
- Shared package (`knight_pkg`) holds:
  - opcode constants `OP_MOVE`=4'h2, `OP_FANFARE`=4'h3;
  - heading constants;
  - `RESP_ACK`=8'hA5, `RESP_POS`=8'h5A;
  - state enum `tour_cmd_state_t`.
- One combinational sub-module, `tour_move_decode`: maps `move`[7:0] to {vert_cmd, horz_cmd}. It is unit-testable on its own.

## Test plan
- Reset: `cmd_UART`=16'h4022, `cmd_rdy_UART`=1 → `cmd`=16'h4022, `cmd_rdy`=1, `resp`=8'hA5, `mv_indx`=0.
- `start_tour` with `move`=8'h01:
  - expect `cmd`=16'h2002, `cmd_rdy`=1;
  - after `clr_cmd_rdy`, `cmd_rdy`=0, `resp`=8'h5A;
  - after `send_resp`, `cmd`=16'h33F1, `cmd_rdy`=1.
- Sweep all eight one-hot `move` values → the vertical/horizontal pairs match the decode list (e.g. 8'h10 → 16'h2FF2 then 16'h37F1).
- Run the full 24-move handshake → `mv_indx` counts 0..23. `resp`=8'h5A on every `send_resp` except the last, which is 8'hA5; the block then returns to IDLE.
- Mid-tour interference:
  - pulse `start_tour` and `cmd_rdy_UART` in HORZ → no restart, `cmd` is unchanged;
  - assert `rst_n`=0 in WAIT_V → IDLE, `mv_indx`=0, `cmd_rdy` follows `cmd_rdy_UART`.
